pc_sequencer: RTL
=================

# pc_sequencer

Program-counter sequencer and run-control FSM for the tinyarch single-cycle core. It owns the PC, accepts a start handshake, and turns the decoder's `jump_mode` plus the ALU zero flag into the next PC each cycle. It detects program end or halt and drives `finished` back into the decoder so that stores are suppressed once the program stops. It sits between the top-level start/done interface, instruction ROM addressing, and the control block.

## Interface
- `PC_W`, 10: PC / instruction-address width.
- `BOOT_ADDR`, 0: first instruction address after start.
- `LAST_ADDR`, 2**PC_W-1: last valid instruction address.
- `CNT_W`, 16: cycle-counter width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level; a rising edge starts a program run.
- `jump_mode`  in  2  from the control block: 0 step, 1 skip-if-nonzero, 2 unconditional skip, 3 absolute jump.
- `alu_zero`  in  1  ALU result == 0 for the current instruction.
- `jump_target`  in  PC_W  absolute target, read from the register file, for `jump_mode` 3.
- `halt`  in  1  the current instruction is the halt encoding.
- `pc`  out  PC_W  current instruction address.
- `run`  out  1  the current instruction is architecturally live; gates reg/mem write enables.
- `finished`  out  1  `~run`; feeds the control block's `finished` input.
- `done`  out  1  program complete; held until the next start.
- `bad_jump`  out  1  sticky flag: the last run ended on an out-of-range target.
- `cycle_count`  out  CNT_W  number of RUN cycles in the current or last run.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - `pc`=BOOT_ADDR; `run`=0; `done`=0.
  - A `start` rising edge (start=1 and last sampled start=0) moves to RUN. It also clears `cycle_count` and `bad_jump`.
- **RUN**
  - One instruction per cycle; `cycle_count` increments by 1 each RUN cycle and saturates at all-ones.
  - Next PC:
    - mode 0: pc+1.
    - mode 1: pc+2 if `!alu_zero`, else pc+1.
    - mode 2: pc+2.
    - mode 3: `jump_target`.
  - Next-PC arithmetic is PC_W+1 bits wide, so there is no silent wrap.
  - Transition to DONE (priority order):
    - `halt`=1: PC holds. Halt wins over any `jump_mode`.
    - Computed next PC > LAST_ADDR from step or skip: PC holds.
    - Mode 3 with `jump_target` > LAST_ADDR: PC holds and `bad_jump` is set.
  - Otherwise stay in RUN and load the next PC.
  - `start` activity during RUN is ignored.
- **DONE**
  - `done`=1; `run`=0; `pc` frozen; `cycle_count` frozen.
  - A `start` rising edge restarts: `pc`=BOOT_ADDR, go to RUN, clear counters.
- Reset (any state, including mid-run):
  - State IDLE, `pc`=BOOT_ADDR.
  - `run`=0, `done`=0, `bad_jump`=0, `cycle_count`=0.
  - Start-edge history = 1. A `start` held high through reset therefore does not auto-launch.

## Timing
- Single-cycle core. The instruction at `pc` is decoded combinationally. Next PC, state and counter update on the same rising edge.
- Start latency: edge seen at clock edge N → `run`=1 and `pc`=BOOT_ADDR during cycle N+1.
- Halt at cycle K: `run`=1 during K, so the decoder must treat halt as a no-op. `done`=1 and `finished`=1 from cycle K+1.
- `cycle_count` includes the halt cycle.
- All outputs are registered or are decodes of registered state; no input-to-output combinational path except none. `finished`=`~run`.

## Structure
- `tinyarch_pkg` holds:
  - `jump_mode_t` enum: JM_STEP=0, JM_SKIP_NZ=1, JM_SKIP=2, JM_JUMP=3. Shared with the control block.
  - `seq_state_t` enum: IDLE, RUN, DONE.
- One combinational sub-module, `pc_next_calc`:
  - Inputs: pc, jump_mode, alu_zero, jump_target.
  - Outputs: next_pc (PC_W+1 bits) and out_of_range.
  - Also reused by the verification model.

## Test plan
- Reset with start=1 held, release reset → stays IDLE, `pc`=0, `done`=0. Drop then raise start → `run`=1 next cycle, `pc`=0.
- Steps at pc=0,1,2; mode 1 at pc=3 with `alu_zero`=0 → `pc`=5. Mode 1 at pc=5 with `alu_zero`=1 → `pc`=6. Mode 2 at pc=6 → `pc`=8.
- Mode 3 with `jump_target`=0x2A → `pc`=0x2A. Mode 3 with `jump_target` > LAST_ADDR (use LAST_ADDR=100, target=101) → `done`=1, `bad_jump`=1, `pc` frozen.
- `halt` with mode 3 in the same cycle at cycle 7 of a run → `done`=1 next cycle, `pc` unchanged, `cycle_count`=7.
- Step at pc=LAST_ADDR → DONE, no wrap to 0. New start edge → `pc`=BOOT_ADDR, `cycle_count`=0, `bad_jump` cleared.
- Assert `reset_n`=0 asynchronously mid-RUN at pc=0x13 → `pc`, `run`, `cycle_count` clear immediately, without waiting for a clock edge. Force `cycle_count` near max → saturates at 0xFFFF.

Source files
------------

// File: rtl/tinyarch_pkg.sv
// Shared types for the tinyarch single-cycle core: jump encodings used by
// the control block and the run-control state encoding of the PC sequencer.
package tinyarch_pkg;

    typedef enum logic [1:0] {
        JM_STEP    = 2'd0,
        JM_SKIP_NZ = 2'd1,
        JM_SKIP    = 2'd2,
        JM_JUMP    = 2'd3
    } jump_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/pc_sequencer_next_calc.sv
// Next-PC calculator for the tinyarch sequencer. The result carries one
// extra bit so that stepping or skipping past the top of the address space
// shows up as out-of-range instead of wrapping back to zero.
module pc_next_calc
    import tinyarch_pkg::*;
#(
    parameter int          PC_W      = 10,
    parameter int unsigned LAST_ADDR = (2**PC_W)-1
) (
    input  logic [PC_W-1:0] i_pc,
    input  jump_mode_t      i_jumpMode,
    input  logic            i_aluZero,
    input  logic [PC_W-1:0] i_jumpTarget,
    output logic [PC_W:0]   o_nextPc,
    output logic            o_outOfRange
);

    localparam logic [PC_W:0] INC_ONE = {{PC_W{1'b0}}, 1'b1};
    localparam logic [PC_W:0] INC_TWO = {{(PC_W-1){1'b0}}, 2'b10};
    localparam logic [PC_W:0] LIMIT   = (PC_W+1)'(LAST_ADDR);

    logic [PC_W:0] w_pcWide;

    assign w_pcWide = {1'b0, i_pc};

    // Select the candidate next address from the decoder's jump request.
    always_comb begin
        o_nextPc = w_pcWide + INC_ONE;
        case (i_jumpMode)
            JM_STEP:    o_nextPc = w_pcWide + INC_ONE;
            JM_SKIP_NZ: o_nextPc = i_aluZero ? (w_pcWide + INC_ONE) : (w_pcWide + INC_TWO);
            JM_SKIP:    o_nextPc = w_pcWide + INC_TWO;
            JM_JUMP:    o_nextPc = {1'b0, i_jumpTarget};
            default:    o_nextPc = w_pcWide + INC_ONE;
        endcase
    end

    assign o_outOfRange = (o_nextPc > LIMIT);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer and run-control FSM for the tinyarch core.
// Owns the PC, launches a run on a start rising edge, advances one
// instruction per cycle and stops on halt or on leaving the program space.
module pc_sequencer
    import tinyarch_pkg::*;
#(
    parameter int          PC_W      = 10,
    parameter int unsigned BOOT_ADDR = 0,
    parameter int unsigned LAST_ADDR = (2**PC_W)-1,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       jump_mode,
    input  logic             alu_zero,
    input  logic [PC_W-1:0]  jump_target,
    input  logic             halt,
    output logic [PC_W-1:0]  pc,
    output logic             run,
    output logic             finished,
    output logic             done,
    output logic             bad_jump,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [PC_W-1:0]  BOOT_PC = PC_W'(BOOT_ADDR);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    seq_state_t       r_state;
    logic [PC_W-1:0]  r_pc;
    logic             r_run;
    logic             r_done;
    logic             r_badJump;
    logic [CNT_W-1:0] r_cycleCount;
    logic             r_startPrev;

    logic             w_startEdge;
    jump_mode_t       w_jumpMode;
    logic [PC_W:0]    w_nextPc;
    logic             w_outOfRange;
    logic             w_leaveSpace;

    assign w_startEdge = start & ~r_startPrev;
    assign w_jumpMode  = jump_mode_t'(jump_mode);

    pc_next_calc #(
        .PC_W      (PC_W),
        .LAST_ADDR (LAST_ADDR)
    ) u_nextCalc (
        .i_pc         (r_pc),
        .i_jumpMode   (w_jumpMode),
        .i_aluZero    (alu_zero),
        .i_jumpTarget (jump_target),
        .o_nextPc     (w_nextPc),
        .o_outOfRange (w_outOfRange)
    );

    // A carry into the extra bit is beyond any address, so it also ends the run.
    assign w_leaveSpace = w_outOfRange | w_nextPc[PC_W];

    // Run-control FSM: PC, state, counter and status flags all update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_pc         <= BOOT_PC;
            r_run        <= 1'b0;
            r_done       <= 1'b0;
            r_badJump    <= 1'b0;
            r_cycleCount <= '0;
            r_startPrev  <= 1'b1;
        end else begin
            r_startPrev <= start;
            case (r_state)
                IDLE, DONE: begin
                    if (w_startEdge) begin
                        r_state      <= RUN;
                        r_pc         <= BOOT_PC;
                        r_run        <= 1'b1;
                        r_done       <= 1'b0;
                        r_badJump    <= 1'b0;
                        r_cycleCount <= '0;
                    end
                end
                RUN: begin
                    if (r_cycleCount != CNT_MAX) begin
                        r_cycleCount <= r_cycleCount + CNT_ONE;
                    end
                    if (halt) begin
                        r_state <= DONE;
                        r_run   <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_leaveSpace) begin
                        r_state <= DONE;
                        r_run   <= 1'b0;
                        r_done  <= 1'b1;
                        if (w_jumpMode == JM_JUMP) begin
                            r_badJump <= 1'b1;
                        end
                    end else begin
                        r_pc <= w_nextPc[PC_W-1:0];
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_pc    <= BOOT_PC;
                    r_run   <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign pc          = r_pc;
    assign run         = r_run;
    assign finished    = ~r_run;
    assign done        = r_done;
    assign bad_jump    = r_badJump;
    assign cycle_count = r_cycleCount;

endmodule
